// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_HIGH
  } uart_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Widest supported data word; narrower words are zero-padded before use.
  localparam int MAX_DATA_BITS = 9;

  // Parity bit a transmitter would send for 'data' in the given mode.
  // Zero padding does not change the XOR, so callers may pass narrow words.
  function automatic logic parity_of(input logic [MAX_DATA_BITS-1:0] data,
                                     input int mode);
    case (mode)
      PAR_ODD:  return ~(^data);
      PAR_EVEN: return ^data;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous bit.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture; both stages take the reset value.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Parametrised UART receiver with valid/ready output and error reporting.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 84,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT);

  logic                     rx_s;
  uart_state_t              state;
  logic [CW-1:0]            cnt;
  logic [3:0]               bit_idx;
  logic [DATA_BITS-1:0]     shreg;
  logic                     perr_r;
  logic                     ferr_r;

  logic                     expire;
  logic [MAX_DATA_BITS-1:0] shreg_ext;
  logic                     exp_par;
  logic                     stop_ferr;
  logic                     last_stop;
  logic                     load;

  sync_2ff #(.RESET_VAL(1'b1)) u_rx_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  assign busy = (state != ST_IDLE);

  // Sample-point, parity and frame-completion decode.
  // The counter expires on 1, so a load of H places the sample H cycles later.
  always_comb begin
    expire                   = (cnt == CW'(1));
    shreg_ext                = '0;
    shreg_ext[DATA_BITS-1:0] = shreg;
    exp_par                  = parity_of(shreg_ext, PARITY);
    stop_ferr                = ferr_r | ~rx_s;
    last_stop                = (state == ST_STOP) && expire &&
                               (bit_idx == 4'(STOP_BITS - 1));
    load                     = last_stop && (!valid || ready);
  end

  // Frame FSM, bit-period counter and shift register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      perr_r  <= 1'b0;
      ferr_r  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            state <= ST_START;
            cnt   <= HALF;
          end
        end
        ST_START: begin
          if (expire) begin
            if (rx_s) begin
              state <= ST_IDLE;
            end else begin
              state   <= ST_DATA;
              bit_idx <= '0;
              cnt     <= FULL;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DATA: begin
          if (expire) begin
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            cnt   <= FULL;
            if (bit_idx == 4'(DATA_BITS - 1)) begin
              bit_idx <= '0;
              perr_r  <= 1'b0;
              ferr_r  <= 1'b0;
              state   <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_PARITY: begin
          if (expire) begin
            perr_r <= (rx_s != exp_par);
            cnt    <= FULL;
            state  <= ST_STOP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_STOP: begin
          if (expire) begin
            ferr_r <= stop_ferr;
            cnt    <= FULL;
            if (bit_idx == 4'(STOP_BITS - 1)) begin
              bit_idx <= '0;
              state   <= rx_s ? ST_IDLE : ST_WAIT_HIGH;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_WAIT_HIGH: begin
          if (rx_s) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Output holding register: a completing frame loads if the slot is free or
  // being consumed this cycle; otherwise it is dropped and flagged as overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      data       <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= last_stop && valid && !ready;
      if (load) begin
        data       <= shreg;
        parity_err <= perr_r;
        frame_err  <= stop_ferr;
        valid      <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx in 8N1, 8E1 and 7O2 configurations.
module tb_uart_rx;

  logic       clk;
  logic       reset;
  logic       line;
  int         sel;

  logic       rx_a, rx_b, rx_c;
  logic       ready_a, ready_b, ready_c;
  logic [7:0] data_a, data_b;
  logic [6:0] data_c;
  logic       valid_a, valid_b, valid_c;
  logic       perr_a, perr_b, perr_c;
  logic       ferr_a, ferr_b, ferr_c;
  logic       ovr_a, ovr_b, ovr_c;
  logic       busy_a, busy_b, busy_c;

  logic [8:0] cur_data;
  logic       cur_valid, cur_perr, cur_ferr, cur_ovr, cur_busy;

  int n_assert = 0;
  int n_fail   = 0;

  int         cyc, rise_cyc, rises, ovr_cnt, ovr_cyc;
  logic       busy_seen, prev_valid;
  logic [8:0] cap_data;
  logic       cap_perr, cap_ferr;

  uart_rx #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .reset(reset), .rx(rx_a), .data(data_a), .valid(valid_a),
    .ready(ready_a), .parity_err(perr_a), .frame_err(ferr_a),
    .overrun(ovr_a), .busy(busy_a));

  uart_rx #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .reset(reset), .rx(rx_b), .data(data_b), .valid(valid_b),
    .ready(ready_b), .parity_err(perr_b), .frame_err(ferr_b),
    .overrun(ovr_b), .busy(busy_b));

  uart_rx #(.CLKS_PER_BIT(16), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_7o2 (
    .clk(clk), .reset(reset), .rx(rx_c), .data(data_c), .valid(valid_c),
    .ready(ready_c), .parity_err(perr_c), .frame_err(ferr_c),
    .overrun(ovr_c), .busy(busy_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rx_a = (sel == 0) ? line : 1'b1;
  assign rx_b = (sel == 1) ? line : 1'b1;
  assign rx_c = (sel == 2) ? line : 1'b1;

  always_comb begin
    case (sel)
      0: begin
        cur_data = {1'b0, data_a}; cur_valid = valid_a; cur_perr = perr_a;
        cur_ferr = ferr_a; cur_ovr = ovr_a; cur_busy = busy_a;
      end
      1: begin
        cur_data = {1'b0, data_b}; cur_valid = valid_b; cur_perr = perr_b;
        cur_ferr = ferr_b; cur_ovr = ovr_b; cur_busy = busy_b;
      end
      default: begin
        cur_data = {2'b0, data_c}; cur_valid = valid_c; cur_perr = perr_c;
        cur_ferr = ferr_c; cur_ovr = ovr_c; cur_busy = busy_c;
      end
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Select a DUT and restart the per-scenario monitor.
  task automatic clear_mon(input int d);
    sel = d;
    #0;
    cyc = 0; rise_cyc = -1; rises = 0; ovr_cnt = 0; ovr_cyc = -1;
    busy_seen = 1'b0; prev_valid = cur_valid;
    cap_data = '0; cap_perr = 1'b0; cap_ferr = 1'b0;
  endtask

  // Advance n cycles, sampling 1 time unit after each rising edge.
  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cur_valid && !prev_valid) begin
        rises++;
        if (rise_cyc < 0) rise_cyc = cyc;
        cap_data = cur_data; cap_perr = cur_perr; cap_ferr = cur_ferr;
      end
      if (cur_ovr) begin
        ovr_cnt++;
        if (ovr_cyc < 0) ovr_cyc = cyc;
      end
      if (cur_busy) busy_seen = 1'b1;
      prev_valid = cur_valid;
    end
  endtask

  // Drive nbits line bits (bit 0 first), 16 cycles each, then idle high.
  task automatic send(input logic [15:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      line = bits[i];
      run_cycles(16);
    end
    line = 1'b1;
  endtask

  function automatic logic [15:0] f8n1(input logic [7:0] b);
    return {6'b0, 1'b1, b, 1'b0};
  endfunction

  function automatic logic [15:0] f8e1(input logic [7:0] b, input logic p);
    return {5'b0, 1'b1, p, b, 1'b0};
  endfunction

  function automatic logic [15:0] f7o2(input logic [6:0] b, input logic p,
                                       input logic s1, input logic s2);
    return {5'b0, s2, s1, p, b, 1'b0};
  endfunction

  initial begin
    reset = 1'b1; line = 1'b1; sel = 0;
    ready_a = 1'b0; ready_b = 1'b0; ready_c = 1'b0;
    clear_mon(0);
    run_cycles(3);
    chk("rst_data",  32'(data_a),  32'h0);
    chk("rst_valid", 32'(valid_a), 32'h0);
    chk("rst_perr",  32'(perr_a),  32'h0);
    chk("rst_ferr",  32'(ferr_a),  32'h0);
    chk("rst_ovr",   32'(ovr_a),   32'h0);
    chk("rst_busy",  32'(busy_a),  32'h0);
    reset = 1'b0;
    run_cycles(5);

    // 8N1 basic: valid rises at 2 sync + 8 + 9*16 + 1 = cycle 155 after the edge.
    ready_a = 1'b1;
    clear_mon(0);
    send(f8n1(8'hA5), 10);
    run_cycles(20);
    chk("8n1_rise_cyc", 32'(rise_cyc), 32'd155);
    chk("8n1_rises",    32'(rises),    32'd1);
    chk("8n1_data",     32'(cap_data), 32'hA5);
    chk("8n1_perr",     32'(cap_perr), 32'h0);
    chk("8n1_ferr",     32'(cap_ferr), 32'h0);
    chk("8n1_valid_clr", 32'(valid_a), 32'h0);

    // 8E1 parity
    ready_b = 1'b1;
    clear_mon(1);
    send(f8e1(8'h03, 1'b0), 11);
    run_cycles(20);
    chk("8e1_ok_rises", 32'(rises),    32'd1);
    chk("8e1_ok_data",  32'(cap_data), 32'h03);
    chk("8e1_ok_perr",  32'(cap_perr), 32'h0);
    clear_mon(1);
    send(f8e1(8'h07, 1'b0), 11);
    run_cycles(20);
    chk("8e1_bad_data", 32'(cap_data), 32'h07);
    chk("8e1_bad_perr", 32'(cap_perr), 32'h1);
    chk("8e1_bad_ferr", 32'(cap_ferr), 32'h0);

    // Glitch rejection then a clean frame
    clear_mon(0);
    line = 1'b0;
    run_cycles(5);
    line = 1'b1;
    run_cycles(9);
    chk("glitch_busy_seen", 32'(busy_seen), 32'h1);
    chk("glitch_busy_idle", 32'(busy_a),    32'h0);
    chk("glitch_no_valid",  32'(rises),     32'd0);
    clear_mon(0);
    send(f8n1(8'h3C), 10);
    run_cycles(20);
    chk("post_glitch_data",  32'(cap_data), 32'h3C);
    chk("post_glitch_rises", 32'(rises),    32'd1);

    // Overrun: second frame completes at 160 + 155 = cycle 315
    ready_a = 1'b0;
    clear_mon(0);
    send(f8n1(8'h11), 10);
    send(f8n1(8'h22), 10);
    run_cycles(20);
    chk("ovr_rises",    32'(rises),    32'd1);
    chk("ovr_held",     32'(data_a),   32'h11);
    chk("ovr_valid",    32'(valid_a),  32'h1);
    chk("ovr_pulses",   32'(ovr_cnt),  32'd1);
    chk("ovr_cyc",      32'(ovr_cyc),  32'd315);
    ready_a = 1'b1;
    run_cycles(1);
    chk("ovr_consumed", 32'(valid_a),  32'h0);

    // Break: 20 bit periods low
    clear_mon(0);
    line = 1'b0;
    run_cycles(320);
    chk("brk_rises",     32'(rises),    32'd1);
    chk("brk_data",      32'(cap_data), 32'h00);
    chk("brk_ferr",      32'(cap_ferr), 32'h1);
    chk("brk_wait_busy", 32'(busy_a),   32'h1);
    line = 1'b1;
    run_cycles(20);
    chk("brk_release", 32'(busy_a), 32'h0);
    clear_mon(0);
    send(f8n1(8'h5A), 10);
    run_cycles(20);
    chk("post_brk_data", 32'(cap_data), 32'h5A);
    chk("post_brk_ferr", 32'(cap_ferr), 32'h0);

    // 7O2 with second stop bit low; 0x55 has four ones so odd parity bit is 1
    clear_mon(2);
    send(f7o2(7'h55, 1'b1, 1'b1, 1'b0), 11);
    run_cycles(20);
    chk("7o2_rises", 32'(rises),    32'd1);
    chk("7o2_data",  32'(cap_data), 32'h55);
    chk("7o2_perr",  32'(cap_perr), 32'h0);
    chk("7o2_ferr",  32'(cap_ferr), 32'h1);
    chk("7o2_held",  32'(valid_c),  32'h1);

    // Reset in the middle of the data bits
    clear_mon(2);
    send(f7o2(7'h2A, 1'b0, 1'b1, 1'b1), 4);
    chk("mid_busy", 32'(busy_c), 32'h1);
    reset = 1'b1;
    run_cycles(1);
    chk("mid_rst_valid", 32'(valid_c), 32'h0);
    chk("mid_rst_data",  32'(data_c),  32'h0);
    chk("mid_rst_ferr",  32'(ferr_c),  32'h0);
    chk("mid_rst_perr",  32'(perr_c),  32'h0);
    chk("mid_rst_busy",  32'(busy_c),  32'h0);
    chk("mid_rst_ovr",   32'(ovr_c),   32'h0);
    reset = 1'b0;
    run_cycles(40);
    ready_c = 1'b1;
    clear_mon(2);
    send(f7o2(7'h2A, 1'b0, 1'b1, 1'b1), 11);
    run_cycles(20);
    chk("post_rst_rises", 32'(rises),    32'd1);
    chk("post_rst_data",  32'(cap_data), 32'h2A);
    chk("post_rst_perr",  32'(cap_perr), 32'h0);
    chk("post_rst_ferr",  32'(cap_ferr), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
